// File: rtl/uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// uart_tx_cfg
// Configurable UART transmitter. Each frame is a start bit, 5..DBIT_MAX data
// bits sent LSB first, an optional even/odd parity bit and 1, 1.5 or 2 stop
// bits. Bit timing comes from an external oversampling strobe (s_tick), with
// OS strobes per bit period.
//
// Optional feature: define UART_TX_BREAK_EN to add the tx_break input and
// the BREAK state. BREAK holds the line low for as long as tx_break is held,
// then gives one bit period of mark before returning to IDLE.
//
// Ports
//   clk          system clock, rising edge
//   reset        synchronous active-high reset
//   s_tick       one-clk oversampling strobe
//   tx_valid     host has a frame to send
//   tx_ready     frame can be accepted (IDLE only)
//   tx_din       frame data, LSB first
//   cfg_dbits    data bit count, clamped to 5..DBIT_MAX
//   cfg_parity   00 none, 01 even, 10 odd, 11 none
//   cfg_stop     00 one, 01 one-and-half, 1x two stop bits
//   tx           registered serial output, idle high
//   tx_busy      high from acceptance until frame end
//   tx_done_tick one-clk pulse, the first IDLE cycle after a frame
//   state_out    current FSM state (debug)
//   tx_break     line break request (UART_TX_BREAK_EN only)
// -----------------------------------------------------------------------------
module uart_tx_cfg #(
  parameter int DBIT_MAX = 8,
  parameter int OS       = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                s_tick,
  input  logic                tx_valid,
  output logic                tx_ready,
  input  logic [DBIT_MAX-1:0] tx_din,
  input  logic [3:0]          cfg_dbits,
  input  logic [1:0]          cfg_parity,
  input  logic [1:0]          cfg_stop,
  output logic                tx,
  output logic                tx_busy,
  output logic                tx_done_tick,
  output logic [2:0]          state_out
`ifdef UART_TX_BREAK_EN
  ,
  input  logic                tx_break
`endif
);

  // The tick counter must reach the longest stop period (2*OS - 1).
  localparam int SW = $clog2(2 * OS);
  localparam logic [SW-1:0] BIT_LAST    = SW'(OS - 1);
  localparam logic [SW-1:0] STOP1_LAST  = SW'(OS - 1);
  localparam logic [SW-1:0] STOP15_LAST = SW'((3 * OS) / 2 - 1);
  localparam logic [SW-1:0] STOP2_LAST  = SW'(2 * OS - 1);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
`ifdef UART_TX_BREAK_EN
    ,
    ST_BREAK  = 3'd5
`endif
  } state_t;

  state_t                state_q, state_d;
  logic [SW-1:0]         s_q, s_d;
  logic [3:0]            n_q, n_d;
  logic [DBIT_MAX-1:0]   data_q, data_d;
  logic [3:0]            dbits_q, dbits_d;
  logic                  par_en_q, par_en_d;
  logic                  par_bit_q, par_bit_d;
  logic [1:0]            stop_q, stop_d;
  logic                  tx_q, tx_d;
  logic                  done_q, done_d;
`ifdef UART_TX_BREAK_EN
  // 0 while the line is held low, 1 during the trailing mark period.
  logic                  brk_mark_q, brk_mark_d;
`endif

  logic [3:0]            dbits_clamp;
  logic [DBIT_MAX-1:0]   dmask;
  logic [SW-1:0]         stop_last;

  // Clamp the requested length into the supported range.
  always_comb begin
    dbits_clamp = cfg_dbits;
    if (cfg_dbits < 4'd5) begin
      dbits_clamp = 4'd5;
    end else if (cfg_dbits > 4'(DBIT_MAX)) begin
      dbits_clamp = 4'(DBIT_MAX);
    end
  end

  // Mask of the data bits that will be sent. Bits above the clamped length
  // must not affect parity, because they are never transmitted.
  for (genvar gi = 0; gi < DBIT_MAX; gi++) begin : g_mask
    assign dmask[gi] = (dbits_clamp > 4'(gi));
  end

  always_comb begin
    case (stop_q)
      2'b00:   stop_last = STOP1_LAST;
      2'b01:   stop_last = STOP15_LAST;
      default: stop_last = STOP2_LAST;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    s_d       = s_q;
    n_d       = n_q;
    data_d    = data_q;
    dbits_d   = dbits_q;
    par_en_d  = par_en_q;
    par_bit_d = par_bit_q;
    stop_d    = stop_q;
    done_d    = 1'b0;
    tx_d      = 1'b1;
`ifdef UART_TX_BREAK_EN
    brk_mark_d = brk_mark_q;
`endif

    case (state_q)
      ST_IDLE: begin
        s_d = '0;
        n_d = '0;
`ifdef UART_TX_BREAK_EN
        if (tx_break) begin
          state_d    = ST_BREAK;
          brk_mark_d = 1'b0;
        end else
`endif
        if (tx_valid) begin
          // Everything the frame needs is captured here, so later changes
          // on the inputs cannot disturb a frame in flight.
          state_d   = ST_START;
          data_d    = tx_din;
          dbits_d   = dbits_clamp;
          par_en_d  = (cfg_parity == 2'b01) || (cfg_parity == 2'b10);
          par_bit_d = (^(tx_din & dmask)) ^ (cfg_parity == 2'b10);
          stop_d    = cfg_stop;
        end
      end

      ST_START: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            state_d = ST_DATA;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d = '0;
            if (n_q == dbits_q - 4'd1) begin
              n_d     = '0;
              state_d = par_en_q ? ST_PARITY : ST_STOP;
            end else begin
              n_d    = n_q + 4'd1;
              data_d = data_q >> 1;
            end
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_PARITY: begin
        if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d     = '0;
            state_d = ST_STOP;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      ST_STOP: begin
        if (s_tick) begin
          if (s_q == stop_last) begin
            s_d     = '0;
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

`ifdef UART_TX_BREAK_EN
      ST_BREAK: begin
        if (!brk_mark_q) begin
          // Bit timing starts only once the break is released.
          s_d = '0;
          if (!tx_break) begin
            brk_mark_d = 1'b1;
          end
        end else if (s_tick) begin
          if (s_q == BIT_LAST) begin
            s_d        = '0;
            brk_mark_d = 1'b0;
            state_d    = ST_IDLE;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end
`endif

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // The line level is derived from where the FSM is going, so tx changes
    // on the same edge as the state and stays a clean registered output.
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = data_d[0];
      ST_PARITY: tx_d = par_bit_d;
`ifdef UART_TX_BREAK_EN
      ST_BREAK:  tx_d = brk_mark_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      s_q       <= '0;
      n_q       <= '0;
      data_q    <= '0;
      dbits_q   <= '0;
      par_en_q  <= 1'b0;
      par_bit_q <= 1'b0;
      stop_q    <= '0;
      tx_q      <= 1'b1;
      done_q    <= 1'b0;
`ifdef UART_TX_BREAK_EN
      brk_mark_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      s_q       <= s_d;
      n_q       <= n_d;
      data_q    <= data_d;
      dbits_q   <= dbits_d;
      par_en_q  <= par_en_d;
      par_bit_q <= par_bit_d;
      stop_q    <= stop_d;
      tx_q      <= tx_d;
      done_q    <= done_d;
`ifdef UART_TX_BREAK_EN
      brk_mark_q <= brk_mark_d;
`endif
    end
  end

  assign tx           = tx_q;
  assign tx_ready     = (state_q == ST_IDLE);
  assign tx_busy      = (state_q != ST_IDLE);
  assign tx_done_tick = done_q;
  assign state_out    = state_q;

endmodule

// File: tb/tb_uart_tx_cfg.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_cfg
// Directed self-checking bench for uart_tx_cfg (DBIT_MAX=8, OS=16).
// s_tick is driven every TDIV clocks. Each frame is checked at the middle of
// every bit period against a hand-computed bit vector (bit 0 = start bit),
// and the number of s_ticks from acceptance to tx_done_tick is checked.
// -----------------------------------------------------------------------------
module tb_uart_tx_cfg;

  localparam int TDIV = 2;
  localparam int OS   = 16;

  logic       clk;
  logic       reset;
  logic       s_tick;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] tx_din;
  logic [3:0] cfg_dbits;
  logic [1:0] cfg_parity;
  logic [1:0] cfg_stop;
  logic       tx;
  logic       tx_busy;
  logic       tx_done_tick;
  logic [2:0] state_out;
`ifdef UART_TX_BREAK_EN
  logic       tx_break;
`endif

  int compared   = 0;
  int mismatched = 0;
  int div        = 0;
  bit prev_tick  = 1'b0;

  uart_tx_cfg #(.DBIT_MAX(8), .OS(OS)) dut (
    .clk          (clk),
    .reset        (reset),
    .s_tick       (s_tick),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_din       (tx_din),
    .cfg_dbits    (cfg_dbits),
    .cfg_parity   (cfg_parity),
    .cfg_stop     (cfg_stop),
    .tx           (tx),
    .tx_busy      (tx_busy),
    .tx_done_tick (tx_done_tick),
    .state_out    (state_out)
`ifdef UART_TX_BREAK_EN
    ,
    .tx_break     (tx_break)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not reach the summary");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: wait for the edge, sample 1 ns later, then set up s_tick for
  // the next edge. prev_tick tells whether s_tick was high at that edge.
  task automatic cyc();
    @(posedge clk);
    #1;
    prev_tick = s_tick;
    div       = (div == TDIV - 1) ? 0 : div + 1;
    s_tick    = (div == 0);
  endtask

  // Send one frame and check it. exp_bits[i] is the i-th bit on the line
  // (start, data, optional parity); nb is how many of them there are.
  task automatic send_frame(input string name, input logic [7:0] din, input logic [3:0] dbits,
                            input logic [1:0] par, input logic [1:0] stop,
                            input logic [15:0] exp_bits, input int nb, input int stop_ticks,
                            input bit keep_valid, input logic [7:0] next_din);
    int guard;
    int ticks;
    int total;
    int done_ticks;
    bit done_seen;
    tx_din     = din;
    cfg_dbits  = dbits;
    cfg_parity = par;
    cfg_stop   = stop;
    tx_valid   = 1'b1;
    guard = 0;
    while (!tx_ready && guard < 2000) begin
      cyc();
      guard++;
    end
    check({name, "_ready_wait"}, 32'(guard < 2000), 32'd1);
    cyc();  // acceptance edge
    if (keep_valid) begin
      tx_din = next_din;
    end else begin
      tx_valid   = 1'b0;
      tx_din     = ~din;
      cfg_dbits  = 4'd6;
      cfg_parity = (par == 2'b00) ? 2'b10 : 2'b00;
      cfg_stop   = (stop == 2'b01) ? 2'b10 : 2'b01;
    end
    check({name, "_acc_tx"}, 32'(tx), 32'd0);
    check({name, "_acc_busy"}, 32'(tx_busy), 32'd1);
    check({name, "_acc_ready"}, 32'(tx_ready), 32'd0);
    check({name, "_acc_state"}, 32'(state_out), 32'd1);
    check({name, "_acc_done"}, 32'(tx_done_tick), 32'd0);

    ticks      = 0;
    done_seen  = 1'b0;
    done_ticks = -1;
    total      = nb * OS + stop_ticks;
    while (!done_seen && ticks <= total + 4) begin
      cyc();
      if (prev_tick) ticks++;
      if (tx_done_tick) begin
        done_seen  = 1'b1;
        done_ticks = ticks;
      end else if (prev_tick) begin
        if ((ticks % OS) == OS / 2 && ticks < nb * OS)
          check($sformatf("%s_bit%0d", name, ticks / OS), 32'(tx), 32'(exp_bits[ticks / OS]));
        if (ticks == nb * OS + stop_ticks / 2)
          check({name, "_stop_mark"}, 32'(tx), 32'd1);
      end
    end
    check({name, "_done_ticks"}, 32'(done_ticks), 32'(total));
    check({name, "_end_ready"}, 32'(tx_ready), 32'd1);
    check({name, "_end_busy"}, 32'(tx_busy), 32'd0);
    check({name, "_end_tx"}, 32'(tx), 32'd1);
    $display("frame %s din=%02h done after %0d ticks (expected %0d)", name, din, done_ticks, total);
  endtask

  initial begin
    int ticks;
    int dn;
    int guard;
`ifdef UART_TX_BREAK_EN
    int bad;
    tx_break = 1'b0;
`endif
    reset      = 1'b1;
    s_tick     = 1'b0;
    tx_valid   = 1'b0;
    tx_din     = 8'h00;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop   = 2'b00;

    // Reset state
    cyc();
    cyc();
    check("rst_tx", 32'(tx), 32'd1);
    check("rst_ready", 32'(tx_ready), 32'd1);
    check("rst_busy", 32'(tx_busy), 32'd0);
    check("rst_done", 32'(tx_done_tick), 32'd0);
    check("rst_state", 32'(state_out), 32'd0);
    $display("reset: tx=%0b ready=%0b busy=%0b state=%0d", tx, tx_ready, tx_busy, state_out);
    reset = 1'b0;
    cyc();

    // 8/none/1, 0xA5: 0,1,0,1,0,0,1,0,1 then stop
    send_frame("t1_a5", 8'hA5, 4'd8, 2'b00, 2'b00, 16'h014A, 9, 16, 1'b0, 8'h00);
    // 7/even/1, 0x41: data 1,0,0,0,0,0,1 parity 0
    send_frame("t2_41", 8'h41, 4'd7, 2'b01, 2'b00, 16'h0082, 9, 16, 1'b0, 8'h00);
    // 5/odd/2, 0xFF: data 1,1,1,1,1 parity 0, stop 32 ticks
    send_frame("t3_ff", 8'hFF, 4'd5, 2'b10, 2'b10, 16'h003E, 7, 32, 1'b0, 8'h00);
    // Back-to-back 8/none/1.5: 0x55 then 0x0F, stop 24 ticks each
    send_frame("t4_55", 8'h55, 4'd8, 2'b00, 2'b01, 16'h00AA, 9, 24, 1'b1, 8'h0F);
    send_frame("t4_0f", 8'h0F, 4'd8, 2'b00, 2'b01, 16'h001E, 9, 24, 1'b0, 8'h00);
    // cfg_dbits=15 clamps to 8, even parity of 0x80 is 1
    send_frame("clamp_hi", 8'h80, 4'd15, 2'b01, 2'b00, 16'h0300, 10, 16, 1'b0, 8'h00);
    // cfg_dbits=0 clamps to 5, 0xE0 sends 0,0,0,0,0 and odd parity 1
    send_frame("clamp_lo", 8'hE0, 4'd0, 2'b10, 2'b00, 16'h0040, 7, 16, 1'b0, 8'h00);
    // parity code 11 means none, stop code 11 means two
    send_frame("par11", 8'h3C, 4'd8, 2'b11, 2'b11, 16'h0078, 9, 32, 1'b0, 8'h00);

    // Reset during data bit 3
    tx_din     = 8'hA5;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop   = 2'b00;
    tx_valid   = 1'b1;
    cyc();  // IDLE, so this edge accepts
    tx_valid = 1'b0;
    ticks = 0;
    guard = 0;
    while (ticks < 4 * OS + 5 && guard < 1000) begin
      cyc();
      guard++;
      if (prev_tick) ticks++;
    end
    check("rst_mid_in_data", 32'(state_out), 32'd2);
    reset = 1'b1;
    cyc();
    reset = 1'b0;
    check("rst_mid_tx", 32'(tx), 32'd1);
    check("rst_mid_state", 32'(state_out), 32'd0);
    check("rst_mid_ready", 32'(tx_ready), 32'd1);
    check("rst_mid_busy", 32'(tx_busy), 32'd0);
    dn = 0;
    for (int i = 0; i < 40; i++) begin
      cyc();
      if (tx_done_tick) dn++;
    end
    check("rst_mid_no_done", 32'(dn), 32'd0);
    $display("reset mid-frame: state=%0d tx=%0b done pulses=%0d", state_out, tx, dn);
    send_frame("after_rst", 8'h96, 4'd8, 2'b01, 2'b00, 16'h012C, 10, 16, 1'b0, 8'h00);

`ifdef UART_TX_BREAK_EN
    // Break wins over a pending frame, then 16 ticks of mark
    tx_din     = 8'hC3;
    cfg_dbits  = 4'd8;
    cfg_parity = 2'b00;
    cfg_stop   = 2'b00;
    tx_valid   = 1'b1;
    tx_break   = 1'b1;
    cyc();
    check("brk_state", 32'(state_out), 32'd5);
    check("brk_tx", 32'(tx), 32'd0);
    check("brk_ready", 32'(tx_ready), 32'd0);
    check("brk_busy", 32'(tx_busy), 32'd1);
    bad   = 0;
    ticks = 0;
    while (ticks < 500) begin
      cyc();
      if (prev_tick) ticks++;
      if (tx !== 1'b0 || state_out !== 3'd5 || tx_done_tick !== 1'b0) bad++;
    end
    check("brk_hold", 32'(bad), 32'd0);
    tx_break = 1'b0;
    cyc();
    check("brk_mark_tx", 32'(tx), 32'd1);
    ticks = 0;
    dn    = 0;
    guard = 0;
    while (!tx_ready && guard < 200) begin
      cyc();
      guard++;
      if (prev_tick) ticks++;
      if (tx_done_tick) dn++;
      if (tx !== 1'b1) dn++;
    end
    check("brk_mark_ticks", 32'(ticks), 32'd16);
    check("brk_no_done", 32'(dn), 32'd0);
    $display("break: 500 ticks low, mark %0d ticks", ticks);
    send_frame("after_brk", 8'hC3, 4'd8, 2'b00, 2'b00, 16'h0186, 9, 16, 1'b0, 8'h00);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
